// File: rtl/multi_ch_bit_sync_pkg.sv
// Shared mode encodings and sizing helpers for the multi-channel bit synchronizer.
// Filter counters are only used when MULTI_CH_BIT_SYNC_FILTER_EN is defined.
package multi_ch_bit_sync_pkg;

  localparam logic [1:0] MODE_LEVEL = 2'b00;
  localparam logic [1:0] MODE_RISE  = 2'b01;
  localparam logic [1:0] MODE_FALL  = 2'b10;
  localparam logic [1:0] MODE_ANY   = 2'b11;

  function automatic int cnt_width(input int len);
    return (len < 1) ? 1 : $clog2(len + 1);
  endfunction

endpackage

// File: rtl/multi_ch_bit_sync_chain.sv
// One-bit synchronizer flop chain with asynchronous active-low reset.
// Exposes the last stage and the value it will take at the next edge.
module sync_chain #(
  parameter int NUM_STAGES = 2
) (
  input  logic CLK,
  input  logic RST_n,
  input  logic d,
  output logic q,
  output logic q_next
);

  logic [NUM_STAGES-1:0] stg_q;
  logic [NUM_STAGES-1:0] stg_d;

  always_comb begin
    stg_d = {stg_q[NUM_STAGES-2:0], d};
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      stg_q <= '0;
    end else begin
      stg_q <= stg_d;
    end
  end

  assign q      = stg_q[NUM_STAGES-1];
  assign q_next = stg_q[NUM_STAGES-2];

endmodule

// File: rtl/multi_ch_bit_sync.sv
// Multi-channel single-bit CDC synchronizer with per-channel edge/pulse modes.
// Define MULTI_CH_BIT_SYNC_FILTER_EN to add a per-channel glitch filter.
module multi_ch_bit_sync
  import multi_ch_bit_sync_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int NUM_STAGES = 2,
  parameter int FILTER_LEN = 3
) (
  input  logic                  CLK,
  input  logic                  RST_n,
  input  logic [NUM_CH-1:0]     ASYNC,
  input  logic [2*NUM_CH-1:0]   MODE,
  output logic [NUM_CH-1:0]     SYNC,
  output logic [NUM_CH-1:0]     PULSE,
  output logic                  ANY_PULSE
);

  logic [NUM_CH-1:0] stg_last;
  logic [NUM_CH-1:0] stg_next;
  logic [NUM_CH-1:0] flt_cur;
  logic [NUM_CH-1:0] flt_nxt;
  logic [NUM_CH-1:0] pulse_q;
  logic [NUM_CH-1:0] pulse_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    sync_chain #(
      .NUM_STAGES (NUM_STAGES)
    ) u_chain (
      .CLK    (CLK),
      .RST_n  (RST_n),
      .d      (ASYNC[g]),
      .q      (stg_last[g]),
      .q_next (stg_next[g])
    );
  end

  if (FILTER_LEN < 1) begin : g_bad_filter_len
  end

`ifdef MULTI_CH_BIT_SYNC_FILTER_EN
  localparam int CW = cnt_width(FILTER_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [CW-1:0]     cnt_q [NUM_CH];
  logic [CW-1:0]     cnt_d [NUM_CH];
  logic [NUM_CH-1:0] flt_q;
  logic [NUM_CH-1:0] flt_d;

  // Level only moves after FILTER_LEN consecutive differing edges.
  always_comb begin
    flt_d = flt_q;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = '0;
      if (stg_last[i] != flt_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          flt_d[i] = stg_last[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      flt_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      flt_q <= flt_d;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign flt_cur = flt_q;
  assign flt_nxt = flt_d;
`else
  assign flt_cur = stg_last;
  assign flt_nxt = stg_next;
`endif

  // Pulse lands on the same edge that SYNC changes.
  always_comb begin
    pulse_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      unique case (MODE[2*i +: 2])
        MODE_LEVEL: pulse_d[i] = 1'b0;
        MODE_RISE:  pulse_d[i] = flt_nxt[i] & ~flt_cur[i];
        MODE_FALL:  pulse_d[i] = ~flt_nxt[i] & flt_cur[i];
        MODE_ANY:   pulse_d[i] = flt_nxt[i] ^ flt_cur[i];
        default:    pulse_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      pulse_q <= '0;
    end else begin
      pulse_q <= pulse_d;
    end
  end

  assign SYNC      = flt_cur;
  assign PULSE     = pulse_q;
  assign ANY_PULSE = |pulse_q;

endmodule

// File: tb/tb_multi_ch_bit_sync.sv
// Directed and random checks of multi_ch_bit_sync against a history-based model.
// Follows MULTI_CH_BIT_SYNC_FILTER_EN the same way as the design.
module tb_multi_ch_bit_sync;

  localparam int NCH = 4;
  localparam int NS  = 4;
  localparam int FL  = 3;

  logic             CLK = 1'b0;
  logic             RST_n = 1'b0;
  logic [NCH-1:0]   ASYNC = '0;
  logic [2*NCH-1:0] MODE = '0;
  logic [NCH-1:0]   SYNC;
  logic [NCH-1:0]   PULSE;
  logic             ANY_PULSE;

  multi_ch_bit_sync #(
    .NUM_CH     (NCH),
    .NUM_STAGES (NS),
    .FILTER_LEN (FL)
  ) dut (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .ASYNC     (ASYNC),
    .MODE      (MODE),
    .SYNC      (SYNC),
    .PULSE     (PULSE),
    .ANY_PULSE (ANY_PULSE)
  );

  always #5 CLK = ~CLK;

  int errs = 0;
  int checks = 0;

  logic [NCH-1:0] hist[$];
  logic [NCH-1:0] m_flt;
  logic [NCH-1:0] m_pulse;
  int             m_run[NCH];
  int             dut_pc[NCH];
  int             mod_pc[NCH];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_flt = '0;
    m_pulse = '0;
    for (int c = 0; c < NCH; c++) m_run[c] = 0;
  endtask

  task automatic clr_counts();
    for (int c = 0; c < NCH; c++) begin
      dut_pc[c] = 0;
      mod_pc[c] = 0;
    end
  endtask

  // Raw synchronized value: the sample captured NS-1 edges ago.
  function automatic logic [NCH-1:0] raw_now();
    if (hist.size() >= NS) return hist[hist.size() - NS];
    return '0;
  endfunction

  task automatic tick();
    logic [NCH-1:0]   a;
    logic [2*NCH-1:0] md;
    logic [NCH-1:0]   r;
    logic [NCH-1:0]   nf;
    bit               chg;
    a  = ASYNC;
    md = MODE;
    @(posedge CLK);
    if (RST_n) begin
      hist.push_back(a);
      r  = raw_now();
      nf = m_flt;
      for (int c = 0; c < NCH; c++) begin
`ifdef MULTI_CH_BIT_SYNC_FILTER_EN
        if (r[c] != m_flt[c]) begin
          m_run[c]++;
          if (m_run[c] >= FL) begin
            nf[c] = r[c];
            m_run[c] = 0;
          end
        end else begin
          m_run[c] = 0;
        end
`else
        nf[c] = r[c];
`endif
        // Mode bit 0 enables rising events, bit 1 enables falling events.
        chg = (nf[c] != m_flt[c]);
        m_pulse[c] = (md[2*c] && chg && nf[c]) ||
                     (md[2*c+1] && chg && !nf[c]);
        if (m_pulse[c]) mod_pc[c]++;
      end
      m_flt = nf;
    end
    #1;
    for (int c = 0; c < NCH; c++) if (PULSE[c]) dut_pc[c]++;
    chk("sync", 32'(SYNC), 32'(m_flt));
    chk("pulse", 32'(PULSE), 32'(m_pulse));
    chk("any_pulse", 32'(ANY_PULSE), 32'(|m_pulse));
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    model_reset();
    clr_counts();
    #2;
    chk("reset_sync", 32'(SYNC), 32'h0);
    chk("reset_pulse", 32'(PULSE), 32'h0);
    chk("reset_any", 32'(ANY_PULSE), 32'h0);
    ticks(2);
    RST_n = 1'b1;

    MODE = 8'b01_01_01_01;
    ticks(9);
    clr_counts();
    ASYNC = 4'b0101;
    ticks(NS + FL + 4);
    chk("t1_pc_ch0", 32'(dut_pc[0]), 32'd1);
    chk("t1_pc_ch1", 32'(dut_pc[1]), 32'd0);
    chk("t1_pc_ch2", 32'(dut_pc[2]), 32'd1);
    chk("t1_sync", 32'(SYNC), 32'h5);

    ASYNC = 4'b0000;
    ticks(NS + FL + 4);
    MODE = 8'b11_10_01_00;
    ticks(2);
    clr_counts();
    ASYNC = 4'b1111;
    ticks(10);
    ASYNC = 4'b0000;
    ticks(10);
    chk("t2_pc_ch0", 32'(dut_pc[0]), 32'd0);
    chk("t2_pc_ch1", 32'(dut_pc[1]), 32'd1);
    chk("t2_pc_ch2", 32'(dut_pc[2]), 32'd1);
    chk("t2_pc_ch3", 32'(dut_pc[3]), 32'd2);

    MODE = 8'b01_01_01_01;
    ticks(2);
    clr_counts();
    ASYNC[0] = 1'b1;
    ticks(2);
    ASYNC[0] = 1'b0;
    ticks(12);
`ifdef MULTI_CH_BIT_SYNC_FILTER_EN
    chk("t3_glitch_pc", 32'(dut_pc[0]), 32'd0);
`else
    chk("t3_glitch_pc", 32'(dut_pc[0]), 32'd1);
`endif
    clr_counts();
    ASYNC[0] = 1'b1;
    ticks(3);
    ASYNC[0] = 1'b0;
    ticks(12);
    chk("t3_long_pc", 32'(dut_pc[0]), 32'd1);

    ASYNC = 4'b1111;
    ticks(NS + 1);
    #2;
    RST_n = 1'b0;
    #1;
    model_reset();
    chk("t4_rst_sync", 32'(SYNC), 32'h0);
    chk("t4_rst_pulse", 32'(PULSE), 32'h0);
    chk("t4_rst_any", 32'(ANY_PULSE), 32'h0);
    ticks(2);
    RST_n = 1'b1;
    clr_counts();
    ticks(NS + FL + 6);
    for (int c = 0; c < NCH; c++) chk("t4_rel_pc", 32'(dut_pc[c]), 32'd1);
    chk("t4_rel_sync", 32'(SYNC), 32'hF);

    MODE = 8'h00;
    ticks(3);
    clr_counts();
    MODE = 8'hFF;
    ticks(5);
    chk("t5_mode_chg_pulse", 32'(dut_pc[0] + dut_pc[3]), 32'd0);
    ASYNC = 4'b0000;
    ticks(NS + FL + 4);
    for (int c = 0; c < NCH; c++) chk("t5_next_pc", 32'(dut_pc[c]), 32'd1);

    clr_counts();
    for (int k = 0; k < 200; k++) begin
      if (k % 50 == 0) MODE = 8'($urandom);
      if ($urandom_range(0, 3) == 0) ASYNC = NCH'($urandom);
      tick();
    end
    for (int c = 0; c < NCH; c++) chk("rnd_pc", 32'(dut_pc[c]), 32'(mod_pc[c]));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/multi_ch_bit_sync.md
Name: multi_ch_bit_sync

Overview:
- Multi-channel synchronizer for asynchronous single-bit inputs, such as control flags and status strobes crossing into the CLK domain.
- Each channel has a configurable-depth flop chain, an optional glitch filter, and an edge/pulse generator selected per channel by mode.
- It replaces ad-hoc single-bit synchronizers at clock-domain boundaries where the consumer needs either a level or a one-cycle event pulse.

Parameters:
- NUM_CH, 4, number of independent 1-bit channels (>=1).
- NUM_STAGES, 2, synchronizer flop depth per channel (>=2).
- FILTER_LEN, 3, consecutive stable cycles required before the filtered level changes (>=1; used only with the filter macro).

Ports:
- CLK  input  1  destination-domain clock; all flops on posedge.
- RST_n  input  1  reset, asynchronous, active-low.
- ASYNC  input  NUM_CH  asynchronous inputs, one bit per channel.
- MODE  input  2*NUM_CH  per-channel mode; bits [2i+1:2i] belong to channel i. Quasi-static, CLK-domain.
- SYNC  output  NUM_CH  synchronized (and optionally filtered) level per channel.
- PULSE  output  NUM_CH  one-cycle event pulse per channel.
- ANY_PULSE  output  1  OR-reduction of PULSE.

Behaviour:
- Reset: RST_n low asynchronously clears every chain stage, filter counter, filtered level, SYNC, PULSE and ANY_PULSE to 0. Reset asserted mid-operation clears everything immediately, with no pending pulses.
- Chain: stage0 <= ASYNC[i]; stage k <= stage k-1. All stages are registered. No combinational path from ASYNC to any output.
- Latency without filter: ASYNC captured at posedge n is visible on SYNC after posedge n+NUM_STAGES-1, i.e. NUM_STAGES edges including the capture edge.
- Filtered level flt[i]: drives SYNC[i]. Without the filter it is the last chain stage itself (no extra flop).
- Mode encoding:
  - 00 LEVEL: PULSE held 0.
  - 01 RISE: pulse when SYNC changes 0->1.
  - 10 FALL: pulse when SYNC changes 1->0.
  - 11 ANY: pulse on either change (toggle-to-pulse use).
- Pulse timing: PULSE[i] is registered and asserted on the same edge at which SYNC[i] changes, for exactly one cycle.
  - Back-to-back SYNC changes on consecutive edges in mode 11 keep PULSE high for two cycles (one per change).
- MODE change: takes effect at the next edge. It never creates a pulse by itself, because pulses depend only on SYNC transitions.
- ANY_PULSE: combinational OR of the registered PULSE bits, so it is glitch-free.
- Channels are fully independent. Simultaneous events on several channels produce simultaneous pulses.
- After reset release with ASYNC[i]=1: SYNC[i] rises after the normal latency. In modes 01/11 exactly one pulse is produced; this is required behaviour, not a bug.
- Input changes shorter than one CLK period may be missed. A metastable resolution shifts the change by at most one cycle.

Optional Feature:
- Macro: MULTI_CH_BIT_SYNC_FILTER_EN.
- When defined, each channel adds a counter of width $clog2(FILTER_LEN+1) and a filtered-level flop.
  - When the last chain stage differs from flt, the counter increments each cycle.
  - When the counter has reached FILTER_LEN-1 and the stage still differs, flt takes the stage value on that edge and the counter clears. The update lands on the FILTER_LEN-th consecutive differing edge.
  - If the stage equals flt on any cycle, the counter clears.
  - Added latency: FILTER_LEN cycles. Pulses follow flt.
- When not defined: no counter, flt = last chain stage, FILTER_LEN ignored.

Decomposition:
- Package multi_ch_bit_sync_pkg holds:
  - MODE_LEVEL=2'b00, MODE_RISE=2'b01, MODE_FALL=2'b10, MODE_ANY=2'b11;
  - a function for counter width.
- Sub-module sync_chain: one-bit NUM_STAGES flop chain with async reset, instantiated NUM_CH times via generate.
- Filter and pulse logic stay in the top module.

Test Plan:
- Reset then ASYNC=4'b0000→4'b0101 at edge 10, MODE=all 01, NUM_STAGES=2, no filter -> SYNC=0101 after edge 11; PULSE=0101 for exactly one cycle; ANY_PULSE=1 for one cycle.
- MODE={11,10,01,00}, toggle every channel 0→1→0 with 6-cycle gaps:
  - ch3 pulses on both edges;
  - ch2 on the fall only;
  - ch1 on the rise only;
  - ch0 never pulses while its SYNC tracks.
- Filter on, FILTER_LEN=3: a 2-cycle high glitch on ch0 -> SYNC/PULSE stay 0. A 3-cycle high -> SYNC rises FILTER_LEN cycles after the unfiltered timing, with one pulse.
- RST_n low mid-transfer, while the chain holds 1s -> all outputs 0 immediately. Release with ASYNC=1, MODE=01 -> exactly one rising pulse after the latency.
- Change MODE from 00 to 11 while SYNC is steady at 1 -> no pulse. The next ASYNC change -> one pulse.
- Random ASYNC, 200 cycles, NUM_STAGES=4 -> a scoreboard confirms SYNC equals ASYNC delayed 4 edges, and a pulse count equals the transition count per mode.
